// File: rtl/fetch_stage_pkg.sv
// Shared ISA and fetch-stage definitions.
//   - ISA_NOP_INSTR / ISA_HALT_OP: default bubble encoding and halting opcode.
//   - OPCODE_MSB / OPCODE_LSB: opcode field position inside a 16-bit instruction.
//   - StIssue..StHalted: fetch controller state encodings.
//   - opcodeOf(): extracts the opcode field from an instruction word.
package fetch_stage_pkg;

  localparam logic [15:0] ISA_NOP_INSTR = 16'h0800;
  localparam logic [4:0]  ISA_HALT_OP   = 5'b00000;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 11;

  localparam logic [2:0] StIssue  = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StDrain  = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
  localparam logic [2:0] StHalted = 3'd4;

  function automatic logic [4:0] opcodeOf(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid buffer for a fetched instruction.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture dataIn and mark full (wins over clear)
//   clear    : mark empty
//   dataIn   : instruction to capture
//   dataOut  : held instruction
//   full     : buffer holds a valid instruction
module fetch_skid_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic        full
);

  logic [15:0] dataQ;
  logic        fullQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      dataQ <= '0;
      fullQ <= 1'b0;
    end else if (load) begin
      dataQ <= dataIn;
      fullQ <= 1'b1;
    end else if (clear) begin
      fullQ <= 1'b0;
    end
  end

  assign dataOut = dataQ;
  assign full    = fullQ;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency
// instruction memory (one outstanding), parks a response in a skid buffer while
// the pipeline is stalled, applies execute-stage redirects and stops on HALT or
// a memory error. Drives the IF/ID register (instruction plus PC+2).
//   clk, rst              : clock, synchronous active-high reset
//   imem_req/imem_addr    : request strobe and address (accepted same cycle)
//   imem_rdy/data/err     : response valid, instruction, error (qualified by rdy)
//   stall                 : hold IF/ID
//   redirect/redirect_pc  : flush and restart fetch at redirect_pc
//   instrOut/nextPcOut    : IF/ID instruction and its PC+2
//   validOut              : IF/ID holds a real instruction
//   halted / err          : fetch stopped / sticky memory error
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = ISA_NOP_INSTR,
  parameter logic [4:0]  HALT_OP   = ISA_HALT_OP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        validOut,
  output logic        halted,
  output logic        err
);

  logic [2:0]  stateQ, stateD;
  logic [15:0] pcQ, pcD;
  logic [15:0] instrQ, instrD;
  logic [15:0] nextPcQ, nextPcD;
  logic        validQ, validD;
  logic        haltedQ, haltedD;
  logic        errQ, errD;

  logic        req;
  logic        accept;
  logic [15:0] acceptInstr;
  logic        skidLoad, skidClear, skidFull;
  logic [15:0] skidData;
  logic [15:0] pcPlus2;

  // While a request is outstanding pc is the address of that request, so the
  // fetched instruction's PC is always pcQ and its successor is pcQ+2.
  assign pcPlus2 = pcQ + 16'd2;

  fetch_skid_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skidLoad),
    .clear   (skidClear),
    .dataIn  (imem_data),
    .dataOut (skidData),
    .full    (skidFull)
  );

  always_comb begin
    stateD      = stateQ;
    pcD         = pcQ;
    haltedD     = haltedQ;
    errD        = errQ;
    req         = 1'b0;
    imem_addr   = pcQ;
    accept      = 1'b0;
    acceptInstr = imem_data;
    skidLoad    = 1'b0;
    skidClear   = 1'b0;

    case (stateQ)
      StIssue: begin
        if (redirect) begin
          pcD = redirect_pc;
        end else begin
          req    = 1'b1;
          stateD = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          pcD    = redirect_pc;
          stateD = imem_rdy ? StIssue : StDrain;
        end else if (imem_rdy) begin
          if (imem_err) begin
            errD    = 1'b1;
            haltedD = 1'b1;
            stateD  = StHalted;
          end else if (stall) begin
            skidLoad = 1'b1;
            stateD   = StHold;
          end else begin
            accept = 1'b1;
          end
        end
      end
      StDrain: begin
        // The stale response is consumed whether or not a new redirect lands.
        if (redirect) pcD = redirect_pc;
        if (imem_rdy) stateD = StIssue;
      end
      StHold: begin
        if (redirect) begin
          skidClear = 1'b1;
          pcD       = redirect_pc;
          stateD    = StIssue;
        end else if (!stall && skidFull) begin
          accept      = 1'b1;
          acceptInstr = skidData;
          skidClear   = 1'b1;
        end
      end
      StHalted: begin
        if (redirect) begin
          haltedD = 1'b0;
          pcD     = redirect_pc;
          stateD  = StIssue;
        end
      end
      default: stateD = StIssue;
    endcase

    if (accept) begin
      pcD = pcPlus2;
      if (opcodeOf(acceptInstr) == HALT_OP) begin
        haltedD = 1'b1;
        stateD  = StHalted;
      end else begin
        // Back-to-back issue of the successor gives one instruction per cycle.
        req       = 1'b1;
        imem_addr = pcPlus2;
        stateD    = StWait;
      end
    end
  end

  // IF/ID: redirect flush beats stall hold beats new instruction.
  always_comb begin
    instrD  = NOP_INSTR;
    nextPcD = nextPcQ;
    validD  = 1'b0;
    if (redirect) begin
      instrD  = NOP_INSTR;
      validD  = 1'b0;
    end else if (stall) begin
      instrD  = instrQ;
      validD  = validQ;
    end else if (accept) begin
      instrD  = acceptInstr;
      nextPcD = pcPlus2;
      validD  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= StIssue;
      pcQ     <= RESET_PC;
      instrQ  <= NOP_INSTR;
      nextPcQ <= '0;
      validQ  <= 1'b0;
      haltedQ <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      pcQ     <= pcD;
      instrQ  <= instrD;
      nextPcQ <= nextPcD;
      validQ  <= validD;
      haltedQ <= haltedD;
      errQ    <= errD;
    end
  end

  // No request while in reset so a reset memory sees a clean start.
  assign imem_req  = req & ~rst;
  assign instrOut  = instrQ;
  assign nextPcOut = nextPcQ;
  assign validOut  = validQ;
  assign halted    = haltedQ;
  assign err       = errQ;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_err = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instrOut;
  logic [15:0] nextPcOut;
  logic        validOut;
  logic        halted;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Memory model controls
  int          lat = 1;
  logic [15:0] errAddr = 16'h1234;
  int          addr2Reqs = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .imem_err    (imem_err),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instrOut    (instrOut),
    .nextPcOut   (nextPcOut),
    .validOut    (validOut),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memRead(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h4000;
      16'h0002: return 16'h4100;
      16'h0004: return 16'h4200;
      16'h0006: return 16'h0000;  // HALT
      16'h0010: return 16'h4500;
      16'h0040: return 16'h4600;
      16'hFFFE: return 16'h4700;
      default:  return 16'h4F00;
    endcase
  endfunction

  // Memory: requests observed mid-cycle, responses driven just after the edge.
  initial begin
    logic        sReq, sRst, pend;
    logic [15:0] sAddr, pAddr;
    int          cnt;
    pend = 1'b0;
    pAddr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      sReq = imem_req;
      sAddr = imem_addr;
      sRst = rst;
      @(posedge clk);
      #1;
      imem_rdy = 1'b0;
      imem_err = 1'b0;
      if (sRst) begin
        pend = 1'b0;
        addr2Reqs = 0;
      end else begin
        if (sReq) begin
          pend = 1'b1;
          pAddr = sAddr;
          cnt = lat - 1;
          if (sAddr == 16'h0002) addr2Reqs++;
        end
        if (pend) begin
          if (cnt == 0) begin
            imem_rdy = 1'b1;
            imem_data = memRead(pAddr);
            imem_err = (pAddr == errAddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic resetDut();
    nxt();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    nxt();
    mid();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then 1-cycle memory streaming 0,2,4 and HALT at 6
    lat = 1;
    resetDut();
    checkEq("rst_valid", 16'(validOut), 16'd0);
    checkEq("rst_instr", instrOut, 16'h0800);
    checkEq("rst_npc", nextPcOut, 16'h0000);
    checkEq("rst_halted", 16'(halted), 16'd0);
    checkEq("rst_err", 16'(err), 16'd0);
    checkEq("rst_req", 16'(imem_req), 16'd0);
    nxt(); rst = 1'b0; mid();
    checkEq("c0_req", 16'(imem_req), 16'd1);
    checkEq("c0_addr", imem_addr, 16'h0000);
    nxt(); mid();
    checkEq("c1_addr", imem_addr, 16'h0002);
    checkEq("c1_valid", 16'(validOut), 16'd0);
    nxt(); mid();
    checkEq("c2_valid", 16'(validOut), 16'd1);
    checkEq("c2_instr", instrOut, 16'h4000);
    checkEq("c2_npc", nextPcOut, 16'h0002);
    checkEq("c2_addr", imem_addr, 16'h0004);
    nxt(); mid();
    checkEq("c3_instr", instrOut, 16'h4100);
    checkEq("c3_npc", nextPcOut, 16'h0004);
    checkEq("c3_addr", imem_addr, 16'h0006);
    nxt(); mid();
    checkEq("c4_instr", instrOut, 16'h4200);
    checkEq("halt_noreq", 16'(imem_req), 16'd0);
    nxt(); mid();
    checkEq("halt_halted", 16'(halted), 16'd1);
    checkEq("halt_instr", instrOut, 16'h0000);
    checkEq("halt_npc", nextPcOut, 16'h0008);
    checkEq("halt_req", 16'(imem_req), 16'd0);
    nxt(); redirect = 1'b1; redirect_pc = 16'h0010; mid();
    checkEq("halt_redir_req", 16'(imem_req), 16'd0);
    checkEq("halt_bubble", 16'(validOut), 16'd0);
    nxt(); redirect = 1'b0; mid();
    checkEq("unhalt", 16'(halted), 16'd0);
    checkEq("unhalt_req", 16'(imem_req), 16'd1);
    checkEq("unhalt_addr", imem_addr, 16'h0010);
    nxt(); mid();
    checkEq("unhalt_addr2", imem_addr, 16'h0012);
    nxt(); mid();
    checkEq("unhalt_instr", instrOut, 16'h4500);
    checkEq("unhalt_npc", nextPcOut, 16'h0012);

    // Stall for 3 cycles while 0x4100 arrives
    resetDut();
    nxt(); rst = 1'b0;
    nxt();
    nxt(); stall = 1'b1; mid();
    checkEq("st0_instr", instrOut, 16'h4000);
    nxt(); mid();
    checkEq("st1_instr", instrOut, 16'h4000);
    checkEq("st1_valid", 16'(validOut), 16'd1);
    checkEq("st1_req", 16'(imem_req), 16'd0);
    nxt(); mid();
    checkEq("st2_req", 16'(imem_req), 16'd0);
    nxt(); stall = 1'b0; mid();
    checkEq("st_rel_req", 16'(imem_req), 16'd1);
    checkEq("st_rel_addr", imem_addr, 16'h0004);
    checkEq("st_rel_hold", instrOut, 16'h4000);
    nxt(); mid();
    checkEq("st_instr", instrOut, 16'h4100);
    checkEq("st_npc", nextPcOut, 16'h0004);
    checkEq("st_addr2_reqs", 16'(addr2Reqs), 16'd1);

    // Redirect with latency 3 and a request outstanding
    lat = 3;
    resetDut();
    nxt(); rst = 1'b0; mid();
    checkEq("rd_first_addr", imem_addr, 16'h0000);
    nxt(); redirect = 1'b1; redirect_pc = 16'h0040; mid();
    checkEq("rd_req0", 16'(imem_req), 16'd0);
    nxt(); redirect = 1'b0; mid();
    checkEq("rd_drain_req", 16'(imem_req), 16'd0);
    checkEq("rd_drain_instr", instrOut, 16'h0800);
    nxt(); mid();
    checkEq("rd_late_req", 16'(imem_req), 16'd0);
    checkEq("rd_late_valid", 16'(validOut), 16'd0);
    nxt(); mid();
    checkEq("rd_new_req", 16'(imem_req), 16'd1);
    checkEq("rd_new_addr", imem_addr, 16'h0040);
    nxt();
    nxt(); mid();
    checkEq("rd_wait_valid", 16'(validOut), 16'd0);
    nxt(); mid();
    checkEq("rd_b2b_addr", imem_addr, 16'h0042);
    nxt(); mid();
    checkEq("rd_instr", instrOut, 16'h4600);
    checkEq("rd_npc", nextPcOut, 16'h0042);

    // Memory error on the response for 0x0002
    lat = 1;
    errAddr = 16'h0002;
    resetDut();
    nxt(); rst = 1'b0;
    nxt();
    nxt(); mid();
    checkEq("er_pre", 16'(err), 16'd0);
    nxt(); mid();
    checkEq("er_err", 16'(err), 16'd1);
    checkEq("er_halted", 16'(halted), 16'd1);
    checkEq("er_valid", 16'(validOut), 16'd0);
    checkEq("er_instr", instrOut, 16'h0800);
    checkEq("er_req", 16'(imem_req), 16'd0);
    nxt(); redirect = 1'b1; redirect_pc = 16'h0010; errAddr = 16'h1234;
    nxt(); redirect = 1'b0; mid();
    checkEq("er_sticky", 16'(err), 16'd1);
    checkEq("er_unhalt", 16'(halted), 16'd0);
    checkEq("er_addr", imem_addr, 16'h0010);

    // Simultaneous redirect and stall with a response arriving, then PC wrap
    resetDut();
    checkEq("rs_err_clr", 16'(err), 16'd0);
    nxt(); rst = 1'b0;
    nxt();
    nxt(); stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040; mid();
    checkEq("rs_pre_instr", instrOut, 16'h4000);
    nxt(); redirect = 1'b0; mid();
    checkEq("rs_valid", 16'(validOut), 16'd0);
    checkEq("rs_instr", instrOut, 16'h0800);
    checkEq("rs_req", 16'(imem_req), 16'd1);
    checkEq("rs_addr", imem_addr, 16'h0040);
    nxt(); stall = 1'b0; mid();
    checkEq("rs_b2b_addr", imem_addr, 16'h0042);
    nxt(); redirect = 1'b1; redirect_pc = 16'hFFFE; mid();
    checkEq("rs_instr2", instrOut, 16'h4600);
    checkEq("rs_npc2", nextPcOut, 16'h0042);
    nxt(); redirect = 1'b0; mid();
    checkEq("wr_addr", imem_addr, 16'hFFFE);
    checkEq("wr_valid0", 16'(validOut), 16'd0);
    nxt(); mid();
    checkEq("wr_next_addr", imem_addr, 16'h0000);
    nxt(); mid();
    checkEq("wr_instr", instrOut, 16'h4700);
    checkEq("wr_npc", nextPcOut, 16'h0000);
    checkEq("wr_valid", 16'(validOut), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
